spi_flash_responder: RTL



---
 rtl/spi_flash_pkg.sv | 31 +++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_flash_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes and state encodings for the emulated serial NOR flash.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_CE   = 8'hC7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        STAT,
        IGNORE,
        ERASE
    } state_t;

    // Deferred effect applied when chip select returns high.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_WREN,
        ACT_WRDI,
        ACT_PP,
        ACT_CE
    } action_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus single-cycle SCK edge and
// chip-select falling-edge pulses in the clk domain.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic cs_n,
    output logic cs_fall,
    output logic mosi,
    output logic sck_rise,
    output logic sck_fall
);

    logic [2:0] cs_q;
    logic [2:0] sck_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_q   <= 3'b111;
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs_n};
            sck_q  <= {sck_q[1:0], spi_sck};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    // Stage 2 is the last flop that is only a delayed copy used for edges.
    assign cs_n     = cs_q[1];
    assign cs_fall  = cs_q[2] & ~cs_q[1];
    assign mosi     = mosi_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash model: read, page program, WEL control,
// status and chip erase over an internal byte array, oversampled on clk.
//
// state  | meaning
// IDLE   | deselected, waiting for chip select to fall
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in the 24-bit address
// RD     | streaming array bytes out on MISO
// WR     | receiving program bytes (AND into the array)
// STAT   | streaming the status register out on MISO
// IGNORE | swallowing bits of an opcode with no data phase
// ERASE  | chip erase running with no transaction in progress
module spi_flash_responder #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_cs_n,
    input  logic          spi_sck,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          busy
);
    import spi_flash_pkg::*;

    logic cs_n, cs_fall, mosi, sck_rise, sck_fall;

    spi_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .cs_n     (cs_n),
        .cs_fall  (cs_fall),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    logic [7:0] mem [DEPTH];

    state_t        state, state_nxt;
    action_t       act, act_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [2:0]    tx_cnt, tx_cnt_nxt;
    logic [7:0]    rx_byte, rx_nxt;
    logic [7:0]    tx_shift, tx_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [AW-1:0] erase_addr, erase_addr_nxt;
    logic          miso, miso_nxt;
    logic          wel, wel_nxt;
    logic          wip, wip_nxt;
    logic          is_read, is_read_nxt;
    logic          pp_we;

    logic [7:0]    rx_shifted;
    logic [AW-1:0] addr_shifted;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] addr_page_inc;
    logic [7:0]    status;
    logic          erase_last;

    assign rx_shifted   = {rx_byte[6:0], mosi};
    assign addr_shifted = {addr[AW-2:0], mosi};
    assign addr_inc     = addr + AW'(1);
    assign status       = {6'b0, wel, wip};
    assign erase_last   = wip && (erase_addr == '1);

    // Program addresses wrap inside the 256-byte page.
    always_comb begin
        addr_page_inc      = addr;
        addr_page_inc[7:0] = addr[7:0] + 8'd1;
    end

    always_comb begin
        state_nxt      = state;
        act_nxt        = act;
        bit_cnt_nxt    = bit_cnt;
        tx_cnt_nxt     = tx_cnt;
        rx_nxt         = rx_byte;
        tx_nxt         = tx_shift;
        addr_nxt       = addr;
        erase_addr_nxt = erase_addr;
        miso_nxt       = miso;
        wel_nxt        = wel;
        wip_nxt        = wip;
        is_read_nxt    = is_read;
        pp_we          = 1'b0;

        if (wip) begin
            erase_addr_nxt = erase_addr + AW'(1);
            if (erase_last) begin
                wip_nxt = 1'b0;
                wel_nxt = 1'b0;
            end
        end

        if (cs_n) begin
            bit_cnt_nxt = '0;
            tx_cnt_nxt  = '0;
            miso_nxt    = 1'b0;
            if (state == ERASE) begin
                if (erase_last) state_nxt = IDLE;
            end else if (state != IDLE) begin
                state_nxt = (wip && !erase_last) ? ERASE : IDLE;
                act_nxt   = ACT_NONE;
                if (!wip) begin
                    case (act)
                        ACT_WREN: wel_nxt = 1'b1;
                        ACT_WRDI: wel_nxt = 1'b0;
                        ACT_PP:   wel_nxt = 1'b0;
                        ACT_CE: begin
                            if (wel) begin
                                wip_nxt        = 1'b1;
                                erase_addr_nxt = '0;
                                state_nxt      = ERASE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            case (state)
                IDLE, ERASE: begin
                    if (cs_fall) begin
                        state_nxt   = CMD;
                        act_nxt     = ACT_NONE;
                        bit_cnt_nxt = '0;
                    end else if (state == ERASE && erase_last) begin
                        state_nxt = IDLE;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_nxt      = rx_shifted;
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = IGNORE;
                            // Only status reads are served while an erase runs.
                            if (wip) begin
                                if (rx_shifted == CMD_RDSR) begin
                                    state_nxt = STAT;
                                    tx_nxt    = status;
                                end
                            end else begin
                                case (rx_shifted)
                                    CMD_READ: begin
                                        state_nxt   = ADDR;
                                        is_read_nxt = 1'b1;
                                    end
                                    CMD_PP: begin
                                        if (wel) begin
                                            state_nxt   = ADDR;
                                            is_read_nxt = 1'b0;
                                            act_nxt     = ACT_PP;
                                        end
                                    end
                                    CMD_WREN: act_nxt = ACT_WREN;
                                    CMD_WRDI: act_nxt = ACT_WRDI;
                                    CMD_CE:   act_nxt = ACT_CE;
                                    CMD_RDSR: begin
                                        state_nxt = STAT;
                                        tx_nxt    = status;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_nxt    = addr_shifted;
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt_nxt = '0;
                            if (is_read) begin
                                tx_nxt     = mem[addr_shifted];
                                tx_cnt_nxt = '0;
                                state_nxt  = RD;
                            end else begin
                                state_nxt = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (sck_fall) begin
                        miso_nxt   = tx_shift[7];
                        tx_nxt     = {tx_shift[6:0], 1'b0};
                        tx_cnt_nxt = tx_cnt + 3'd1;
                        if (tx_cnt == 3'd7) begin
                            addr_nxt = addr_inc;
                            tx_nxt   = mem[addr_inc];
                        end
                    end
                end
                STAT: begin
                    if (sck_fall) begin
                        miso_nxt   = tx_shift[7];
                        tx_nxt     = {tx_shift[6:0], 1'b0};
                        tx_cnt_nxt = tx_cnt + 3'd1;
                        if (tx_cnt == 3'd7) tx_nxt = status;
                    end
                end
                WR: begin
                    if (sck_rise) begin
                        rx_nxt      = rx_shifted;
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            pp_we       = 1'b1;
                            addr_nxt    = addr_page_inc;
                        end
                    end
                end
                IGNORE: begin
                    // Any bit past the opcode cancels its deferred effect.
                    if (sck_rise) act_nxt = ACT_NONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            act        <= ACT_NONE;
            bit_cnt    <= '0;
            tx_cnt     <= '0;
            rx_byte    <= '0;
            tx_shift   <= '0;
            addr       <= '0;
            erase_addr <= '0;
            miso       <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            is_read    <= 1'b0;
        end else begin
            state      <= state_nxt;
            act        <= act_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_cnt     <= tx_cnt_nxt;
            rx_byte    <= rx_nxt;
            tx_shift   <= tx_nxt;
            addr       <= addr_nxt;
            erase_addr <= erase_addr_nxt;
            miso       <= miso_nxt;
            wel        <= wel_nxt;
            wip        <= wip_nxt;
            is_read    <= is_read_nxt;
        end
    end

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = load_data;
        if (wip) begin
            mem_we    = 1'b1;
            mem_waddr = erase_addr;
            mem_wdata = 8'hFF;
        end else if (pp_we) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = mem[addr] & rx_shifted;
        end else if (load_we && cs_n) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign spi_miso = miso;
    assign busy     = wip;

endmodule
